word_reader: RTL and testbench

- Requester-side (reader) end of the team's toggle command/response I/O handshake.
- On `start`, toggles `device_command`, waits for `device_response` to match it, then captures `device_data` into a held output word and pulses `done`.
- Sits between the CPU datapath and any device read port. The captured word feeds the datapath the same way a `register` output does.

---
 rtl/io_pkg.sv | 23 ++
 rtl/register.sv | 36 +++
 rtl/word_reader.sv | 152 +++++++++++++++
 tb/tb_word_reader.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// ----------------------------------------------------------------------------
// io_pkg
// Shared definitions for the toggle command/response I/O handshake blocks.
//   state_t                 : requester FSM states (IDLE, WAIT)
//   DEFAULT_DATA_WIDTH      : default device word width
//   DEFAULT_TIMEOUT_CYCLES  : default WAIT cycles before abort (timeout build)
//   wait_cnt_width()        : bits needed to count up to a given cycle limit
// ----------------------------------------------------------------------------
package io_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

    function automatic int wait_cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/register.sv
// ----------------------------------------------------------------------------
// register
// Generic clock-qualified holding register.
//   clock       in   rising-edge clock
//   clock_valid in   qualifies every edge; 0 freezes the stored value
//   reset       in   synchronous active-high clear (only on valid edges)
//   write       in   load strobe
//   d           in   WIDTH data in
//   q           out  WIDTH stored value
// ----------------------------------------------------------------------------
module register #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clock_valid,
    input  logic             reset,
    input  logic             write,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (clock_valid) begin
            if (reset) begin
                r_q <= '0;
            end else if (write) begin
                r_q <= d;
            end
        end
    end

    assign q = r_q;

endmodule

// File: rtl/word_reader.sv
// ----------------------------------------------------------------------------
// word_reader
// Requester end of the toggle command/response handshake. A start toggles
// device_command; once device_response equals it the device word is captured
// into data_out and done pulses for one valid cycle.
//
// Optional feature macro: READER_TIMEOUT_EN
//   When defined, a WAIT cycle counter aborts the read after TIMEOUT_CYCLES
//   valid WAIT cycles (done + error, data_out unchanged) and adds the error port.
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   synchronous active-high, honoured only when clock_valid=1
//   clock_valid     in   qualifies every edge; 0 freezes all state
//   start           in   request one read (sampled in IDLE)
//   device_response in   toggle returned by the device
//   device_data     in   DATA_WIDTH device word
//   device_command  out  toggle to the device, one per read
//   busy            out  high while waiting for the device
//   done            out  one-cycle pulse on capture (or timeout)
//   data_out        out  DATA_WIDTH last captured word
//   error           out  timeout flag (READER_TIMEOUT_EN only)
// ----------------------------------------------------------------------------
module word_reader
    import io_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH
`ifdef READER_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
`endif
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clock_valid,
    input  logic                  start,
    input  logic                  device_response,
    input  logic [DATA_WIDTH-1:0] device_data,
    output logic                  device_command,
    output logic                  busy,
    output logic                  done,
`ifdef READER_TIMEOUT_EN
    output logic                  error,
`endif
    output logic [DATA_WIDTH-1:0] data_out
);

    state_t r_state;
    logic   r_command;
    logic   r_busy;
    logic   r_done;
    logic   w_match;
    logic   w_capture;

`ifdef READER_TIMEOUT_EN
    localparam int                LP_CNT_W = wait_cnt_width(TIMEOUT_CYCLES);
    // Counter holds the number of WAIT edges already spent; the edge on which
    // it equals LP_LAST is the TIMEOUT_CYCLES-th WAIT edge.
    localparam logic [LP_CNT_W-1:0] LP_LAST = LP_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [LP_CNT_W-1:0] r_wait_cnt;
    logic                r_error;
`endif

    assign w_match   = (device_response == r_command);
    // Capture strobe feeds the data register; reset has priority inside it.
    assign w_capture = (r_state == WAIT) && w_match;

    always_ff @(posedge clock) begin
        if (clock_valid) begin
            if (reset) begin
                r_state   <= IDLE;
                r_command <= 1'b0;
                r_busy    <= 1'b0;
                r_done    <= 1'b0;
`ifdef READER_TIMEOUT_EN
                r_wait_cnt <= '0;
                r_error    <= 1'b0;
`endif
            end else begin
                r_done <= 1'b0;
                case (r_state)
                    IDLE: begin
                        if (start) begin
                            r_command <= ~r_command;
                            r_busy    <= 1'b1;
                            r_state   <= WAIT;
`ifdef READER_TIMEOUT_EN
                            r_wait_cnt <= '0;
                            r_error    <= 1'b0;
`endif
                        end
                    end
                    WAIT: begin
                        if (w_match) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end
`ifdef READER_TIMEOUT_EN
                        else if (r_wait_cnt == LP_LAST) begin
                            // Abort: command stays toggled, data_out untouched.
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
`endif
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    // Capture register: shared register block at the native 32-bit width,
    // an equivalent local flop otherwise.
    generate
        if (DATA_WIDTH == 32) begin : g_shared_reg
            register #(
                .WIDTH(DATA_WIDTH)
            ) u_data_reg (
                .clock      (clock),
                .clock_valid(clock_valid),
                .reset      (reset),
                .write      (w_capture),
                .d          (device_data),
                .q          (data_out)
            );
        end else begin : g_local_reg
            logic [DATA_WIDTH-1:0] r_data;
            always_ff @(posedge clock) begin
                if (clock_valid) begin
                    if (reset) begin
                        r_data <= '0;
                    end else if (w_capture) begin
                        r_data <= device_data;
                    end
                end
            end
            assign data_out = r_data;
        end
    endgenerate

    assign device_command = r_command;
    assign busy           = r_busy;
    assign done           = r_done;
`ifdef READER_TIMEOUT_EN
    assign error          = r_error;
`endif

endmodule

// File: tb/tb_word_reader.sv
module tb_word_reader;

    logic        clock = 1'b0;
    logic        reset;
    logic        clock_valid;
    logic        start;
    logic        device_response;
    logic [31:0] device_data;
    logic        device_command;
    logic        busy;
    logic        done;
    logic [31:0] data_out;
`ifdef READER_TIMEOUT_EN
    logic        error;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    word_reader #(
        .DATA_WIDTH(32)
`ifdef READER_TIMEOUT_EN
      , .TIMEOUT_CYCLES(8)
`endif
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .clock_valid    (clock_valid),
        .start          (start),
        .device_response(device_response),
        .device_data    (device_data),
        .device_command (device_command),
        .busy           (busy),
        .done           (done),
`ifdef READER_TIMEOUT_EN
        .error          (error),
`endif
        .data_out       (data_out)
    );

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        device_response = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        clock_valid = 1'b1;
        start = 1'b0;
        device_data = 32'h0;
        do_reset();
        checks++; if (device_command !== 1'b0) begin errors++; $display("FAIL rst_cmd got %b want 0", device_command); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL rst_data got %h want 00000000", data_out); end
        $display("reset: cmd=%b busy=%b done=%b data_out=%h", device_command, busy, done, data_out);
    endtask

    task automatic test_single_read();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sr_busy_start got %b want 1", busy); end
        checks++; if (device_command !== 1'b1) begin errors++; $display("FAIL sr_cmd got %b want 1", device_command); end
        tick();
        tick();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL sr_waiting got busy=%b done=%b want busy=1 done=0", busy, done); end
        device_data = 32'hDEADBEEF;
        device_response = 1'b1;
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL sr_done got %b want 1", done); end
        checks++; if (data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_data got %h want deadbeef", data_out); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sr_busy_end got %b want 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL sr_done_pulse got %b want 0", done); end
        checks++; if (data_out !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_data_hold got %h want deadbeef", data_out); end
        $display("single read: data_out=%h", data_out);
    endtask

    task automatic test_back_to_back();
        do_reset();
        start = 1'b1;
        tick();
        checks++; if (device_command !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL b2b_first got cmd=%b busy=%b want 1 1", device_command, busy); end
        device_response = 1'b1;
        device_data = 32'h00000001;
        tick();
        checks++; if (done !== 1'b1 || data_out !== 32'h00000001) begin errors++; $display("FAIL b2b_cap1 got done=%b data=%h want 1 00000001", done, data_out); end
        $display("b2b read 1: data_out=%h", data_out);
        tick();
        checks++; if (device_command !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL b2b_second got cmd=%b busy=%b done=%b want 0 1 0", device_command, busy, done); end
        start = 1'b0;
        device_response = 1'b0;
        device_data = 32'h00000002;
        tick();
        checks++; if (done !== 1'b1 || data_out !== 32'h00000002) begin errors++; $display("FAIL b2b_cap2 got done=%b data=%h want 1 00000002", done, data_out); end
        $display("b2b read 2: data_out=%h", data_out);
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_clock_valid();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (device_command !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL cv_start got cmd=%b busy=%b want 1 1", device_command, busy); end
        clock_valid = 1'b0;
        device_response = 1'b1;
        device_data = 32'hA5A55A5A;
        reset = 1'b1;  // must be ignored while the edge is not valid
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b1 || data_out !== 32'h00000002 || device_command !== 1'b1) begin
                errors++;
                $display("FAIL cv_frozen%0d got done=%b busy=%b cmd=%b data=%h want 0 1 1 00000002", i, done, busy, device_command, data_out);
            end
        end
        reset = 1'b0;
        clock_valid = 1'b1;
        tick();
        checks++; if (done !== 1'b1 || data_out !== 32'hA5A55A5A || busy !== 1'b0) begin errors++; $display("FAIL cv_capture got done=%b busy=%b data=%h want 1 0 a5a55a5a", done, busy, data_out); end
        $display("gated read: data_out=%h", data_out);
        tick();
    endtask

    task automatic test_reset_mid_wait();
        // command=1, response=1 here; a new start moves command to 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (device_command !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rmw_start got cmd=%b busy=%b want 0 1", device_command, busy); end
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        device_response = 1'b0;
        checks++; if (device_command !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0) begin
            errors++; $display("FAIL rmw_reset got cmd=%b busy=%b done=%b data=%h want 0 0 0 00000000", device_command, busy, done, data_out);
        end
        // Spurious response toggle while idle.
        device_response = 1'b1;
        device_data = 32'h00001234;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || data_out !== 32'h0 || device_command !== 1'b0) begin
                errors++; $display("FAIL rmw_spurious%0d got done=%b busy=%b cmd=%b data=%h want 0 0 0 00000000", i, done, busy, device_command, data_out);
            end
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (device_command !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL rmw_retoggle got cmd=%b done=%b want 1 0", device_command, done); end
        tick();
        checks++; if (done !== 1'b1 || data_out !== 32'h00001234) begin errors++; $display("FAIL rmw_read got done=%b data=%h want 1 00001234", done, data_out); end
        $display("read after reset: data_out=%h", data_out);
        tick();
    endtask

`ifdef READER_TIMEOUT_EN
    task automatic test_timeout();
        // command=1, response=1, data_out=00001234. Start toggles command to 0.
        device_data = 32'hFFFFFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || error !== 1'b0 || busy !== 1'b1) begin
                errors++; $display("FAIL to_wait%0d got done=%b error=%b busy=%b want 0 0 1", i, done, error, busy);
            end
        end
        tick();
        checks++; if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_abort got done=%b error=%b busy=%b want 1 1 0", done, error, busy); end
        checks++; if (data_out !== 32'h00001234 || device_command !== 1'b0) begin errors++; $display("FAIL to_hold got data=%h cmd=%b want 00001234 0", data_out, device_command); end
        $display("timeout read: error=%b data_out=%h", error, data_out);
        tick();
        checks++; if (done !== 1'b0 || error !== 1'b1) begin errors++; $display("FAIL to_after got done=%b error=%b want 0 1", done, error); end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (error !== 1'b0 || device_command !== 1'b1) begin errors++; $display("FAIL to_clear got error=%b cmd=%b want 0 1", error, device_command); end
        tick();
        checks++; if (done !== 1'b1 || data_out !== 32'hFFFFFFFF || error !== 1'b0) begin errors++; $display("FAIL to_next got done=%b error=%b data=%h want 1 0 ffffffff", done, error, data_out); end
        $display("read after timeout: data_out=%h", data_out);
    endtask
`endif

    initial begin
        reset = 1'b1;
        clock_valid = 1'b1;
        start = 1'b0;
        device_response = 1'b0;
        device_data = 32'h0;
        test_reset();
        test_single_read();
        test_back_to_back();
        test_clock_valid();
        test_reset_mid_wait();
`ifdef READER_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
